// File: rtl/ika9958_cpu_regwr.sv
// ika9958_cpu_regwr -- CPU port write decoder for a V9958-style VDP.
//
// This block turns CPU strobes into register-file writes and VRAM address
// setups:
//   port 1 : two-byte sequence. The first byte is latched. The second byte
//            either writes a register (10aaaaaa), sets up a VRAM address
//            (0Rhhhhhh), or does nothing (11xxxxxx).
//   port 3 : indirect register write through pointer R#17. This port is
//            only present when IKA9958_INDIRECT_EN is defined.
//   port 0/2 : ignored here.
//
// Ports
//   i_EMUCLK                  clock (rising edge)
//   i_RST                     synchronous active-high reset
//   i_WR, i_RD                one-cycle CPU write / read strobes
//   i_PORT[1:0], i_DIN[7:0]   port select and write data
//   o_REG_WE, o_REG_ADDR[5:0], o_REG_DATA[7:0]   register-file write pulse
//   o_VAS_WE, o_VAS_ADDR[13:0], o_VAS_RW         VRAM address-setup pulse
//   o_R17[7:0]                indirect pointer register R#17
//
// Parameter NUM_REGS: register numbers >= NUM_REGS produce no write pulse.
// Macro IKA9958_INDIRECT_EN: enables the port-3 indirect access path.
module ika9958_cpu_regwr #(
    parameter int NUM_REGS = 47
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST,
    input  logic        i_WR,
    input  logic        i_RD,
    input  logic [1:0]  i_PORT,
    input  logic [7:0]  i_DIN,
    output logic        o_REG_WE,
    output logic [5:0]  o_REG_ADDR,
    output logic [7:0]  o_REG_DATA,
    output logic        o_VAS_WE,
    output logic [13:0] o_VAS_ADDR,
    output logic        o_VAS_RW,
    output logic [7:0]  o_R17
);

    localparam int unsigned NREGS_U = NUM_REGS;

    logic       ff;      // 1: the next port-1 write is the second byte
    logic [7:0] latch;   // first byte of the port-1 sequence
    logic [7:0] r17;

    logic wr1, rd1, ff_eff, second, reg1, vas1, reg1_ok;
    logic ind_wr, ind_ok;

    assign o_R17 = r17;

    assign wr1    = i_WR && (i_PORT == 2'd1);
    assign rd1    = i_RD && (i_PORT == 2'd1);
    // A simultaneous read clears the flip-flop first, so the write lands as a first byte.
    assign ff_eff = ff && !rd1;
    assign second = wr1 && ff_eff;
    assign reg1   = second && (i_DIN[7:6] == 2'b10);
    assign vas1   = second && !i_DIN[7];
    assign reg1_ok = ({26'd0, i_DIN[5:0]} < NREGS_U);

`ifdef IKA9958_INDIRECT_EN
    assign ind_wr = i_WR && (i_PORT == 2'd3);
`else
    assign ind_wr = 1'b0;
`endif
    // The pointer register itself cannot be written indirectly.
    assign ind_ok = (r17[5:0] != 6'd17) && ({26'd0, r17[5:0]} < NREGS_U);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            ff         <= 1'b0;
            latch      <= 8'h00;
            r17        <= 8'h00;
            o_REG_WE   <= 1'b0;
            o_REG_ADDR <= 6'd0;
            o_REG_DATA <= 8'h00;
            o_VAS_WE   <= 1'b0;
            o_VAS_ADDR <= 14'd0;
            o_VAS_RW   <= 1'b0;
        end else begin
            o_REG_WE <= 1'b0;
            o_VAS_WE <= 1'b0;

            if (wr1) begin
                if (!ff_eff) begin
                    latch <= i_DIN;
                    ff    <= 1'b1;
                end else begin
                    ff <= 1'b0;
                end
            end else if (rd1) begin
                ff <= 1'b0;
            end

            if (reg1) begin
                if (reg1_ok) begin
                    o_REG_WE   <= 1'b1;
                    o_REG_ADDR <= i_DIN[5:0];
                    o_REG_DATA <= latch;
                end
                // R#17 tracks its writes even when the pulse is suppressed.
                if (i_DIN[5:0] == 6'd17)
                    r17 <= latch;
            end

            if (vas1) begin
                o_VAS_WE   <= 1'b1;
                o_VAS_ADDR <= {i_DIN[5:0], latch};
                o_VAS_RW   <= i_DIN[6];
            end

            if (ind_wr) begin
                if (ind_ok) begin
                    o_REG_WE   <= 1'b1;
                    o_REG_ADDR <= r17[5:0];
                    o_REG_DATA <= i_DIN;
                end
                // Auto-increment wraps within the 6-bit field and leaves bit 6 alone.
                if (!r17[7])
                    r17[5:0] <= r17[5:0] + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_ika9958_cpu_regwr.sv
module tb_ika9958_cpu_regwr;

    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [1:0]  port;
    logic [7:0]  din;
    logic        reg_we, vas_we, vas_rw;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data, r17;
    logic [13:0] vas_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ika9958_cpu_regwr #(.NUM_REGS(47)) dut (
        .i_EMUCLK  (clk),
        .i_RST     (rst),
        .i_WR      (wr),
        .i_RD      (rd),
        .i_PORT    (port),
        .i_DIN     (din),
        .o_REG_WE  (reg_we),
        .o_REG_ADDR(reg_addr),
        .o_REG_DATA(reg_data),
        .o_VAS_WE  (vas_we),
        .o_VAS_ADDR(vas_addr),
        .o_VAS_RW  (vas_rw),
        .o_R17     (r17)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of strobes, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [1:0] p, input logic [7:0] d);
        wr = w; rd = r; port = p; din = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic w1(input logic [7:0] d);
        step(1'b1, 1'b0, 2'd1, d);
    endtask

    task automatic w3(input logic [7:0] d);
        step(1'b1, 1'b0, 2'd3, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; port = 2'd0; din = 8'h00;
        #2;
        idle(); idle();
        chk("rst_reg_we", {15'd0, reg_we}, 16'd0);
        chk("rst_vas_we", {15'd0, vas_we}, 16'd0);
        chk("rst_reg_addr", {10'd0, reg_addr}, 16'd0);
        chk("rst_reg_data", {8'd0, reg_data}, 16'd0);
        chk("rst_vas_addr", {2'd0, vas_addr}, 16'd0);
        chk("rst_vas_rw", {15'd0, vas_rw}, 16'd0);
        chk("rst_r17", {8'd0, r17}, 16'd0);
        rst = 1'b0;

        // Register write: 0x5A then 0x87
        w1(8'h5A);
        chk("rw_first_no_pulse", {14'd0, reg_we, vas_we}, 16'd0);
        w1(8'h87);
        chk("rw_we", {15'd0, reg_we}, 16'd1);
        chk("rw_addr", {10'd0, reg_addr}, 16'd7);
        chk("rw_data", {8'd0, reg_data}, 16'h5A);
        chk("rw_no_vas", {15'd0, vas_we}, 16'd0);
        idle();
        chk("rw_one_cycle", {15'd0, reg_we}, 16'd0);
        chk("rw_addr_hold", {10'd0, reg_addr}, 16'd7);

        // VRAM setup: 0x34 then 0x52
        w1(8'h34); w1(8'h52);
        chk("vas_we", {15'd0, vas_we}, 16'd1);
        chk("vas_addr", {2'd0, vas_addr}, 16'h1234);
        chk("vas_rw", {15'd0, vas_rw}, 16'd1);
        chk("vas_no_reg", {15'd0, reg_we}, 16'd0);
        idle();
        chk("vas_one_cycle", {15'd0, vas_we}, 16'd0);
        chk("vas_addr_hold", {2'd0, vas_addr}, 16'h1234);

        // Read clears FF mid-sequence
        w1(8'h11); step(1'b0, 1'b1, 2'd1, 8'h00);
        w1(8'h22);
        chk("rd_clear_no_pulse", {15'd0, reg_we}, 16'd0);
        w1(8'h81);
        chk("rd_clear_addr", {10'd0, reg_addr}, 16'd1);
        chk("rd_clear_data", {8'd0, reg_data}, 16'h22);

        // 11xxxxxx second byte is a no-op but clears FF
        w1(8'hAB); w1(8'hC5);
        chk("noop_pulses", {14'd0, reg_we, vas_we}, 16'd0);
        w1(8'h66); w1(8'h83);
        chk("noop_then_addr", {10'd0, reg_addr}, 16'd3);
        chk("noop_then_data", {8'd0, reg_data}, 16'h66);

        // Ports 0 and 2 leave FF alone
        w1(8'h44); step(1'b1, 1'b0, 2'd0, 8'h99); step(1'b0, 1'b1, 2'd2, 8'h00);
        w1(8'h85);
        chk("p02_addr", {10'd0, reg_addr}, 16'd5);
        chk("p02_data", {8'd0, reg_data}, 16'h44);

        // Simultaneous read and write: write becomes a first byte
        w1(8'h12); step(1'b1, 1'b1, 2'd1, 8'h77);
        chk("rdwr_no_pulse", {14'd0, reg_we, vas_we}, 16'd0);
        w1(8'h86);
        chk("rdwr_addr", {10'd0, reg_addr}, 16'd6);
        chk("rdwr_data", {8'd0, reg_data}, 16'h77);

        // Register range boundary: 48 suppressed, 46 written
        w1(8'hAA); w1(8'hB0);
        chk("oor_no_pulse", {15'd0, reg_we}, 16'd0);
        chk("oor_addr_hold", {10'd0, reg_addr}, 16'd6);
        w1(8'h55); w1(8'hAE);
        chk("last_reg_we", {15'd0, reg_we}, 16'd1);
        chk("last_reg_addr", {10'd0, reg_addr}, 16'd46);

        // Reset between the two bytes; strobe during reset is ignored
        w1(8'h33);
        rst = 1'b1; w1(8'h99); rst = 1'b0;
        chk("mid_rst_addr", {10'd0, reg_addr}, 16'd0);
        chk("mid_rst_we", {15'd0, reg_we}, 16'd0);
        w1(8'h01); w1(8'h82);
        chk("mid_rst_after_addr", {10'd0, reg_addr}, 16'd2);
        chk("mid_rst_after_data", {8'd0, reg_data}, 16'h01);

        // R17 = 0x3F through port 1
        w1(8'h3F); w1(8'h91);
        chk("r17_set_we", {15'd0, reg_we}, 16'd1);
        chk("r17_set_addr", {10'd0, reg_addr}, 16'd17);
        chk("r17_set_val", {8'd0, r17}, 16'h3F);
        w3(8'hAA);
`ifdef IKA9958_INDIRECT_EN
        chk("ind63_no_pulse", {15'd0, reg_we}, 16'd0);
        chk("ind63_r17", {8'd0, r17}, 16'h00);
        w3(8'hBB);
        chk("ind0_we", {15'd0, reg_we}, 16'd1);
        chk("ind0_addr", {10'd0, reg_addr}, 16'd0);
        chk("ind0_data", {8'd0, reg_data}, 16'hBB);
        chk("ind0_r17", {8'd0, r17}, 16'h01);
`else
        chk("p3_off_no_pulse", {15'd0, reg_we}, 16'd0);
        chk("p3_off_r17", {8'd0, r17}, 16'h3F);
        w3(8'hBB);
        chk("p3_off_r17_b", {8'd0, r17}, 16'h3F);
`endif

        // R17 = 0x90: no auto-increment
        w1(8'h90); w1(8'h91);
        chk("r17_90", {8'd0, r17}, 16'h90);
        for (int i = 1; i <= 3; i++) begin
            w3(8'(i));
`ifdef IKA9958_INDIRECT_EN
            chk("hold_we", {15'd0, reg_we}, 16'd1);
            chk("hold_addr", {10'd0, reg_addr}, 16'd16);
            chk("hold_data", {8'd0, reg_data}, 16'(i));
`else
            chk("hold_off_we", {15'd0, reg_we}, 16'd0);
`endif
            chk("hold_r17", {8'd0, r17}, 16'h90);
        end

        // Indirect write to R17 is blocked but still increments
        w1(8'h11); w1(8'h91);
        w3(8'hEE);
        chk("blk17_no_pulse", {15'd0, reg_we}, 16'd0);
`ifdef IKA9958_INDIRECT_EN
        chk("blk17_r17", {8'd0, r17}, 16'h12);
`else
        chk("blk17_r17", {8'd0, r17}, 16'h11);
`endif

        // Increment wraps in 6 bits and keeps bit 6
        w1(8'h7F); w1(8'h91);
        w3(8'h01);
`ifdef IKA9958_INDIRECT_EN
        chk("wrap_r17", {8'd0, r17}, 16'h40);
`else
        chk("wrap_r17", {8'd0, r17}, 16'h7F);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ika9958_cpu_regwr.md
IKA9958_CPU_REGWR -- requirements
Module: IKA9958_cpu_regwr

Interface
REQ-001 SHALL have parameter NUM_REGS, default 47: register addresses >= NUM_REGS are ignored (no write pulse).
REQ-002 SHALL have port i_EMUCLK, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_RST, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port i_WR, input, 1: one-cycle CPU write strobe.
REQ-005 SHALL have port i_RD, input, 1: one-cycle CPU read strobe.
REQ-006 SHALL have port i_PORT, input, 2: port select (0..3).
REQ-007 SHALL have port i_DIN, input, 8: CPU write data.
REQ-008 SHALL have port o_REG_WE, output, 1: one-cycle register-file write pulse.
REQ-009 SHALL have port o_REG_ADDR, output, 6: register number for o_REG_WE.
REQ-010 SHALL have port o_REG_DATA, output, 8: register data for o_REG_WE.
REQ-011 SHALL have port o_VAS_WE, output, 1: one-cycle VRAM address-setup pulse.
REQ-012 SHALL have port o_VAS_ADDR, output, 14: VRAM address low bits.
REQ-013 SHALL have port o_VAS_RW, output, 1: VRAM setup direction, 1 = write setup.
REQ-014 SHALL have port o_R17, output, 8: current indirect pointer register R#17.

Function
REQ-015 SHALL define a port-1 byte flip-flop FF. FF=0 means the next port-1 write is the first byte; FF=1 means it is the second byte.
REQ-016 SHALL handle a port-1 write with FF=0 as follows: latch i_DIN into LATCH and set FF=1; no output pulse.
REQ-017 SHALL handle a port-1 write with FF=1 and i_DIN[7:6]=2'b10 as a register write: addr=i_DIN[5:0], data=LATCH; clear FF.
REQ-018 SHALL handle a port-1 write with FF=1 and i_DIN[7]=0 as a VRAM setup: o_VAS_ADDR={i_DIN[5:0],LATCH}, o_VAS_RW=i_DIN[6], pulse o_VAS_WE; clear FF.
REQ-019 SHALL treat a port-1 second byte with i_DIN[7:6]=2'b11 as a no-op, while still clearing FF.
REQ-020 SHALL clear FF on any port-1 read (i_RD=1, i_PORT=1).
REQ-021 SHALL give the read priority when i_RD and i_WR are both asserted on port 1: clear FF first, then process the write as a first byte.
REQ-022 SHALL implement the port-3 write (indirect access) as: addr=R17[5:0], data=i_DIN, pulse o_REG_WE.
REQ-023 SHALL increment R17[5:0] modulo 64 after each port-3 write when R17[7]=0; R17[6] is unaffected by the increment.
REQ-024 SHALL hold R17 unchanged after a port-3 write when R17[7]=1.
REQ-025 SHALL block a port-3 write whose target is address 17 (no pulse), while still applying the auto-increment rule.
REQ-026 SHALL update o_R17 on any register write to address 17 made via port 1, in the same cycle that o_REG_WE is pulsed.
REQ-027 SHALL, for a write to address >= NUM_REGS, suppress o_REG_WE while still updating FF and R17 normally.
REQ-028 SHALL assert o_REG_WE and o_VAS_WE exactly one cycle after the qualifying i_WR cycle, each for one cycle, and never both in the same cycle.
REQ-029 SHALL hold o_REG_ADDR, o_REG_DATA, o_VAS_ADDR and o_VAS_RW stable until the next pulse.
REQ-030 SHALL ignore writes and reads on ports 0 and 2; they do not affect FF.
REQ-031 SHALL accept back-to-back strobes every cycle with no stall.

Reset
REQ-032 SHALL, while i_RST=1, set FF=0, LATCH=0, R17=0, o_REG_WE=0, o_VAS_WE=0, o_REG_ADDR=0, o_REG_DATA=0, o_VAS_ADDR=0 and o_VAS_RW=0.
REQ-033 SHALL discard any pending first byte on reset mid-sequence; the next port-1 write after reset is a first byte.
REQ-034 SHALL ignore strobes in any cycle where i_RST=1.

Configuration
REQ-035 SHALL gate indirect access behind macro IKA9958_INDIRECT_EN: when defined, REQ-022 to REQ-025 apply; when undefined, port-3 writes are ignored (no pulse, R17 does not increment), and R17 remains writable via port 1.

Verification
REQ-036 SHALL cover port-1 writes 0x5A then 0x87 -> one cycle later o_REG_WE=1, o_REG_ADDR=7, o_REG_DATA=0x5A; FF=0.
REQ-037 SHALL cover port-1 writes 0x34 then 0x52 -> o_VAS_WE=1, o_VAS_ADDR=0x1234, o_VAS_RW=1; o_REG_WE stays 0.
REQ-038 SHALL cover port-1 write 0x11, then a port-1 read, then port-1 writes 0x22 and 0x81 -> o_REG_ADDR=1, o_REG_DATA=0x22.
REQ-039 SHALL cover R17 set to 0x3F via port 1, then port-3 writes 0xAA and 0xBB -> writes go to addr 63 then addr 0 with no pulse for addr 63 (NUM_REGS=47); R17 reads 0x00 then 0x01.
REQ-040 SHALL cover R17 set to 0x90 via port 1, then three port-3 writes -> three pulses to addr 16; R17 stays 0x90.
REQ-041 SHALL cover reset asserted between the two port-1 bytes, then port-1 writes 0x01 and 0x82 -> o_REG_ADDR=2, o_REG_DATA=0x01.
